jtag_scan_ctrl: RTL and testbench
=================================

// Module: jtag_scan_ctrl
// PURPOSE
// - Host-side JTAG scan sequencer. It converts IR/DR scan commands into TCK/TMS/TDI bit streams and captures TDO.
// - Sits between a bus or command master and the JTAG pins of a jtag_tap-based target.
// - Tracks the target TAP state internally. It always parks the TAP in Run-Test/Idle between commands.
// PARAMETERS
// - MAX_LEN  32  Maximum number of shift bits per scan; width of the TDI and TDO data ports.
// - CLK_DIV  2   Half-period of TCK, in i_clk cycles; must be >= 1.
// PORTS
// - i_clk        in   1        System clock; the only clock.
// - i_rst        in   1        Synchronous, active-high reset.
// - i_cmdValid   in   1        Command valid.
// - o_cmdReady   out  1        Command ready.
// - i_cmdType    in   2        00 DR scan, 01 IR scan, 10 TAP reset, 11 reserved.
// - i_cmdLen     in   LW       Shift length; LW = $clog2(MAX_LEN+1).
// - i_cmdTdi     in   MAX_LEN  TDI data, shifted out LSB first.
// - o_rspValid   out  1        Response valid.
// - i_rspReady   in   1        Response ready.
// - o_rspTdo     out  MAX_LEN  Captured TDO. Bit i is the i-th shifted bit; bits >= len read 0.
// - o_tck        out  1        JTAG TCK.
// - o_tms        out  1        JTAG TMS.
// - o_tdi        out  1        JTAG TDI.
// - i_tdo        in   1        JTAG TDO; assumed already synchronous to i_clk.
// BEHAVIOUR
// - Reset values: o_tck=0, o_tms=1, o_tdi=0, o_cmdReady=0, o_rspValid=0, o_rspTdo=0.
// - Bit timing: each JTAG bit is a TCK-low phase of CLK_DIV cycles followed by a TCK-high phase of CLK_DIV cycles.
//   - TMS and TDI are updated on the first cycle of the low phase.
//   - TDO is sampled on the i_clk cycle where TCK rises.
// - FSM states: INIT -> IDLE -> HDR -> SHIFT -> TAIL -> RESP -> IDLE.
// - INIT: after reset, emit 5 bits with TMS=1 and then 1 bit with TMS=0, leaving the TAP in Idle. Then enter IDLE.
// - IDLE: o_cmdReady=1 and TCK is held low. A command is accepted when i_cmdValid && o_cmdReady.
//   - On acceptance, latch type, len and tdi. Clamp len to MAX_LEN if it is larger.
// - HDR: emit the header TMS sequence.
//   - DR header: 1,0,0 (Select-DR, Capture-DR, Shift-DR).
//   - IR header: 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
// - SHIFT: emit len bits. TDI is tdi[i]. TMS is 0 except on the last bit, where TMS=1 (Exit1). TDO is captured into bit i.
// - TAIL: emit TMS 1,0 (Update, then Idle).
// - RESP: o_rspValid=1 until i_rspReady is high. Then return to IDLE.
//   - o_rspTdo is stable while o_rspValid is high.
// - o_cmdReady is 0 in every state except IDLE, so only one command is in flight.
// - len==0: skip HDR, SHIFT and TAIL. Go straight to RESP with o_rspTdo=0. No TCK edges occur.
// - Reserved type 11: handled like len==0, with no TCK activity.
// - Latency for an N-bit scan: o_rspValid rises the cycle after the last TAIL high phase ends.
//   - DR scan: (5+N)*2*CLK_DIV cycles after acceptance.
//   - IR scan: (6+N)*2*CLK_DIV cycles after acceptance.
// - TDI and TMS are never changed while TCK is high.
// - i_rst mid-scan: all outputs return to their reset values on the next cycle, then INIT runs again.
// - When TCK is idle, TMS is held 0 (TAP stays in Idle).
// CONFIGURATION
// - JTAG_SCAN_RESET_CMD_EN defined: type 10 emits 5 bits with TMS=1 and then 1 bit with TMS=0, then enters RESP with o_rspTdo=0.
// - JTAG_SCAN_RESET_CMD_EN undefined: type 10 is treated as reserved (no TCK activity, immediate RESP).
// STRUCTURE
// - jtag_pa (shared package) holds:
//   - ty_SCAN_CMD enum {SCAN_DR, SCAN_IR, SCAN_RESET, SCAN_RSVD}.
//   - ty_STATE_SCAN_FSM enum.
//   - Header constants: HDR_DR = 3'b001 (length 3) and HDR_IR = 4'b0011 (length 4), both emitted LSB first.
// - Sub-module jtag_tck_gen: counts CLK_DIV and produces o_tck plus one-cycle fall and rise strobes.
//   - It runs only while its enable input is high and holds TCK low when disabled.
// TESTING
// - Power-up: release i_rst, count TCK rises -> TMS bits read 1,1,1,1,1,0. o_cmdReady rises after the 6th bit.
// - DR scan, len=8, tdi=0xA5, TDO looped back from TDI via a jtag_tap plus 1-bit bypass model:
//   - TMS reads 1,0,0,0x7 then 1, then 1,0.
//   - o_rspTdo = 0xA5 shifted by one bit with bit0 = 0 (the bypass capture value), i.e. 0x4A.
// - IR scan, len=4, i_tdo tied 1:
//   - TMS reads 1,1,0,0,0,0,0,1,1,0.
//   - TDI reads tdi[0..3].
//   - o_rspTdo = 0xF.
//   - o_rspValid rises exactly 10*2*CLK_DIV cycles after acceptance.
// - len=0 and type 11: no TCK edge occurs and o_rspValid rises within 2 cycles.
//   - Hold i_rspReady=0 for 20 cycles: o_rspValid and o_rspTdo stay stable and o_cmdReady stays 0.
// - Assert i_rst during SHIFT of a 16-bit DR scan: the next cycle shows o_tck=0, o_tms=1, o_rspValid=0, then the INIT sequence repeats.
// - With JTAG_SCAN_RESET_CMD_EN: a type-10 command gives TMS 1,1,1,1,1,0 and then a response of 0.
//   - The bench TAP model (jtag_tap) passes through Reset and ends in Idle.

Source files
------------

// File: rtl/jtag_scan_ctrl_pkg.sv
// jtag_pa: shared types and TMS header constants for the JTAG scan sequencer.
package jtag_pa;
   typedef enum logic [1:0] {SCAN_DR, SCAN_IR, SCAN_RESET, SCAN_RSVD} ty_SCAN_CMD;
   typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_HDR, ST_SHIFT, ST_TAIL, ST_RESP} ty_STATE_SCAN_FSM;
   localparam logic [2:0] HDR_DR = 3'b001;
   localparam logic [3:0] HDR_IR = 4'b0011;
   localparam int HDR_DR_LEN = 3;
   localparam int HDR_IR_LEN = 4;
   function automatic logic hdrBit(input logic isIr, input logic [1:0] idx);
      logic [3:0] v;
      v = isIr ? HDR_IR : {1'b0, HDR_DR};
      return v[idx];
   endfunction
endpackage

// File: rtl/jtag_scan_ctrl_tck_gen.sv
// jtag_tck_gen: TCK divider; low phase then high phase of CLK_DIV cycles each, with
// o_rise on the cycle TCK goes high and o_fall on the last cycle of each bit.
module jtag_tck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   output logic o_tck,
   output logic o_fall,
   output logic o_rise
);
   localparam int CW = $clog2(2 * CLK_DIV);
   localparam logic [CW-1:0] HALF = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge i_clk) begin
      if (i_rst || !i_en) begin
         cnt   <= '0;
         o_tck <= 1'b0;
      end else begin
         cnt   <= (cnt == LAST) ? '0 : cnt + CW'(1);
         o_tck <= (cnt == HALF) ? 1'b1 : (cnt == LAST) ? 1'b0 : o_tck;
      end
   end
   assign o_rise = i_en && cnt == HALF;
   assign o_fall = i_en && cnt == LAST;
endmodule

// File: rtl/jtag_scan_ctrl.sv
// jtag_scan_ctrl: host-side JTAG sequencer turning DR/IR scan commands into TCK/TMS/TDI and capturing TDO.
// Define JTAG_SCAN_RESET_CMD_EN to enable the type-10 TAP reset command (otherwise it acts as reserved).
module jtag_scan_ctrl
   import jtag_pa::*;
#(
   parameter int MAX_LEN = 32,
   parameter int CLK_DIV = 2,
   localparam int LW = $clog2(MAX_LEN + 1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_cmdValid,
   output logic               o_cmdReady,
   input  logic [1:0]         i_cmdType,
   input  logic [LW-1:0]      i_cmdLen,
   input  logic [MAX_LEN-1:0] i_cmdTdi,
   output logic               o_rspValid,
   input  logic               i_rspReady,
   output logic [MAX_LEN-1:0] o_rspTdo,
   output logic               o_tck,
   output logic               o_tms,
   output logic               o_tdi,
   input  logic               i_tdo
);
   localparam int CW = (LW > 3) ? LW : 3;
   localparam logic [CW-1:0] MAXL = CW'(MAX_LEN);
   ty_STATE_SCAN_FSM state, stateNx;
   ty_SCAN_CMD typ, typNx;
   logic [CW-1:0] bitCnt, cntNx, len, lenNx, cmdLen;
   logic [MAX_LEN-1:0] tdiReg, tdiNx, tdoReg;
   logic tmsNx, tdiBitNx, tckEn, tckFall, tckRise, accept, doScan, doReset;

   jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tckGen (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(tckEn),
      .o_tck(o_tck), .o_fall(tckFall), .o_rise(tckRise)
   );

   assign tckEn      = state inside {ST_INIT, ST_HDR, ST_SHIFT, ST_TAIL};
   assign accept     = state == ST_IDLE && i_cmdValid;
   assign cmdLen     = CW'(i_cmdLen);
   assign doScan     = ty_SCAN_CMD'(i_cmdType) inside {SCAN_DR, SCAN_IR} && cmdLen != '0;
`ifdef JTAG_SCAN_RESET_CMD_EN
   assign doReset    = ty_SCAN_CMD'(i_cmdType) == SCAN_RESET;
`else
   assign doReset    = 1'b0;
`endif
   assign o_cmdReady = state == ST_IDLE;
   assign o_rspValid = state == ST_RESP;
   assign o_rspTdo   = tdoReg;

   // Position (state, bit index) only moves on acceptance or at the end of a bit,
   // so TMS/TDI derived from the next position only change while TCK is low.
   always_comb begin
      stateNx  = state;
      cntNx    = bitCnt;
      typNx    = typ;
      lenNx    = len;
      tdiNx    = tdiReg;
      tmsNx    = 1'b0;
      tdiBitNx = 1'b0;
      if (accept) begin
         typNx   = ty_SCAN_CMD'(i_cmdType);
         lenNx   = (cmdLen > MAXL) ? MAXL : cmdLen;
         tdiNx   = i_cmdTdi;
         cntNx   = '0;
         stateNx = doReset ? ST_INIT : doScan ? ST_HDR : ST_RESP;
      end else if (tckFall) begin
         cntNx = bitCnt + CW'(1);
         case (state)
            ST_INIT:  if (bitCnt == CW'(5)) stateNx = (typ == SCAN_RESET) ? ST_RESP : ST_IDLE;
            ST_HDR:   if (bitCnt == ((typ == SCAN_IR) ? CW'(HDR_IR_LEN - 1) : CW'(HDR_DR_LEN - 1))) stateNx = ST_SHIFT;
            ST_SHIFT: if (bitCnt == len - CW'(1)) stateNx = ST_TAIL;
            ST_TAIL:  if (bitCnt == CW'(1)) stateNx = ST_RESP;
            default:  ;
         endcase
         if (stateNx != state) cntNx = '0;
      end else if (state == ST_RESP && i_rspReady) begin
         stateNx = ST_IDLE;
      end
      case (stateNx)
         ST_INIT:  tmsNx = cntNx < CW'(5);
         ST_HDR:   tmsNx = hdrBit(typNx == SCAN_IR, cntNx[1:0]);
         ST_SHIFT: begin
            tmsNx    = cntNx == lenNx - CW'(1);
            tdiBitNx = |(tdiNx & (MAX_LEN'(1) << cntNx));
         end
         ST_TAIL:  tmsNx = cntNx == '0;
         default:  ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= ST_INIT;
         bitCnt <= '0;
         typ    <= SCAN_DR;
         len    <= '0;
         tdiReg <= '0;
         tdoReg <= '0;
         o_tms  <= 1'b1;
         o_tdi  <= 1'b0;
      end else begin
         state  <= stateNx;
         bitCnt <= cntNx;
         typ    <= typNx;
         len    <= lenNx;
         tdiReg <= tdiNx;
         o_tms  <= tmsNx;
         o_tdi  <= tdiBitNx;
         tdoReg <= accept ? '0 : (state == ST_SHIFT && tckRise) ? tdoReg | (MAX_LEN'(i_tdo) << bitCnt) : tdoReg;
      end
   end
endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// tb_jtag_scan_ctrl: directed bench for jtag_scan_ctrl with a TAP + 1-bit bypass target model.
// Exercises the type-10 reset command when JTAG_SCAN_RESET_CMD_EN is defined.
module tb_jtag_scan_ctrl;
   typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
                             SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR} tap_t;

   logic i_clk = 1'b0, i_rst = 1'b1, i_cmdValid = 1'b0, i_rspReady = 1'b0;
   logic [1:0] i_cmdType = 2'b00;
   logic [5:0] i_cmdLen = '0;
   logic [31:0] i_cmdTdi = '0;
   logic o_cmdReady, o_rspValid, o_tck, o_tms, o_tdi, i_tdo;
   logic [31:0] o_rspTdo;
   logic tdoTie = 1'b0, tapTdo = 1'b0, bypass = 1'b0;
   tap_t tapSt = RTI;
   int nRise = 0, tlrCnt = 0, viol = 0, nCmp = 0, nErr = 0;
   logic tmsLog [0:1023];
   logic tdiLog [0:1023];
   logic prevTck = 1'b0, prevTms = 1'b1, prevTdi = 1'b0;

   jtag_scan_ctrl dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_cmdValid(i_cmdValid), .o_cmdReady(o_cmdReady),
      .i_cmdType(i_cmdType), .i_cmdLen(i_cmdLen), .i_cmdTdi(i_cmdTdi),
      .o_rspValid(o_rspValid), .i_rspReady(i_rspReady), .o_rspTdo(o_rspTdo),
      .o_tck(o_tck), .o_tms(o_tms), .o_tdi(o_tdi), .i_tdo(i_tdo)
   );

   always #5 i_clk = ~i_clk;
   assign i_tdo = tdoTie ? 1'b1 : tapTdo;

   function automatic tap_t tapNext(input tap_t s, input logic tms);
      case (s)
         TLR:     return tms ? TLR   : RTI;
         RTI:     return tms ? SELDR : RTI;
         SELDR:   return tms ? SELIR : CAPDR;
         CAPDR:   return tms ? EX1DR : SHDR;
         SHDR:    return tms ? EX1DR : SHDR;
         EX1DR:   return tms ? UPDR  : PAUDR;
         PAUDR:   return tms ? EX2DR : PAUDR;
         EX2DR:   return tms ? UPDR  : SHDR;
         UPDR:    return tms ? SELDR : RTI;
         SELIR:   return tms ? TLR   : CAPIR;
         CAPIR:   return tms ? EX1IR : SHIR;
         SHIR:    return tms ? EX1IR : SHIR;
         EX1IR:   return tms ? UPIR  : PAUIR;
         PAUIR:   return tms ? EX2IR : PAUIR;
         EX2IR:   return tms ? UPIR  : SHIR;
         default: return tms ? SELDR : RTI;
      endcase
   endfunction

   // Target TAP: bypass captures 0 and shifts TDI; TDO updates on the falling edge.
   always @(posedge o_tck) begin
      if (tapSt == CAPDR) bypass <= 1'b0;
      else if (tapSt == SHDR) bypass <= o_tdi;
      if (tapSt == TLR) tlrCnt <= tlrCnt + 1;
      tapSt <= tapNext(tapSt, o_tms);
      if (nRise < 1024) begin
         tmsLog[nRise] <= o_tms;
         tdiLog[nRise] <= o_tdi;
      end
      nRise <= nRise + 1;
   end
   always @(negedge o_tck) tapTdo <= bypass;

   always @(negedge i_clk) begin
      if (prevTck && o_tck && (o_tms !== prevTms || o_tdi !== prevTdi)) viol++;
      prevTck = o_tck;
      prevTms = o_tms;
      prevTdi = o_tdi;
   end

   function automatic logic [63:0] gather(input bit selTdi, input int s, input int n);
      logic [63:0] r = '0;
      for (int k = 0; k < n; k++) r[k] = selTdi ? tdiLog[s + k] : tmsLog[s + k];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic waitReady(input string tag);
      int n = 0;
      while (o_cmdReady !== 1'b1 && n < 400) begin
         @(negedge i_clk);
         n++;
      end
      chk(tag, o_cmdReady, 1);
   endtask

   task automatic issue(input logic [1:0] t, input logic [5:0] l, input logic [31:0] d, output int lat);
      i_cmdType = t; i_cmdLen = l; i_cmdTdi = d; i_cmdValid = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_cmdValid = 1'b0;
      lat = 0;
      while (o_rspValid !== 1'b1 && lat < 500) begin
         @(negedge i_clk);
         lat++;
      end
   endtask

   task automatic ack();
      i_rspReady = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_rspReady = 1'b0;
   endtask

   initial begin
      int s, lat, t0;
      logic stable;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_tck", o_tck, 0);
      chk("rst_tms", o_tms, 1);
      chk("rst_tdi", o_tdi, 0);
      chk("rst_ready", o_cmdReady, 0);
      chk("rst_rspValid", o_rspValid, 0);
      chk("rst_rspTdo", o_rspTdo, 0);
      s = nRise;
      i_rst = 1'b0;
      waitReady("init_ready");
      chk("init_rises", nRise - s, 6);
      chk("init_tms", gather(0, s, 6), 64'h1F);
      chk("init_tap", tapSt, RTI);
      chk("idle_tms", o_tms, 0);

      // DR scan through the bypass loopback
      s = nRise;
      issue(2'b00, 6'd8, 32'hA5, lat);
      chk("dr_lat", lat, 52);
      chk("dr_rises", nRise - s, 13);
      chk("dr_tms", gather(0, s, 13), 64'hC01);
      chk("dr_tdi", gather(1, s + 3, 8), 64'hA5);
      chk("dr_tdo", o_rspTdo, 32'h4A);
      chk("dr_busy", o_cmdReady, 0);
      ack();
      chk("dr_ack_valid", o_rspValid, 0);
      chk("dr_ack_ready", o_cmdReady, 1);
      chk("dr_tap", tapSt, RTI);

      // IR scan with TDO tied high
      tdoTie = 1'b1;
      s = nRise;
      issue(2'b01, 6'd4, 32'h9, lat);
      chk("ir_lat", lat, 40);
      chk("ir_rises", nRise - s, 10);
      chk("ir_tms", gather(0, s, 10), 64'h183);
      chk("ir_tdi", gather(1, s + 4, 4), 64'h9);
      chk("ir_tdo", o_rspTdo, 32'hF);
      ack();
      chk("ir_tap", tapSt, RTI);
      tdoTie = 1'b0;

      // len==0: immediate response, held for 20 cycles without ready
      s = nRise;
      issue(2'b00, 6'd0, 32'hFFFF, lat);
      chk("len0_fast", lat <= 2, 1);
      chk("len0_tdo", o_rspTdo, 0);
      stable = 1'b1;
      repeat (20) begin
         @(negedge i_clk);
         if (o_rspValid !== 1'b1 || o_rspTdo !== 32'h0 || o_cmdReady !== 1'b0) stable = 1'b0;
      end
      chk("len0_hold", stable, 1);
      chk("len0_rises", nRise - s, 0);
      ack();

      // reserved type
      s = nRise;
      issue(2'b11, 6'd5, 32'h1F, lat);
      chk("rsvd_fast", lat <= 2, 1);
      chk("rsvd_tdo", o_rspTdo, 0);
      chk("rsvd_rises", nRise - s, 0);
      ack();

      // type 10
      s = nRise;
      t0 = tlrCnt;
      issue(2'b10, 6'd5, 32'h1F, lat);
`ifdef JTAG_SCAN_RESET_CMD_EN
      chk("rcmd_lat", lat, 24);
      chk("rcmd_rises", nRise - s, 6);
      chk("rcmd_tms", gather(0, s, 6), 64'h1F);
      chk("rcmd_tlr", tlrCnt > t0, 1);
`else
      chk("rcmd_fast", lat <= 2, 1);
      chk("rcmd_rises", nRise - s, 0);
      chk("rcmd_tlr", tlrCnt - t0, 0);
`endif
      chk("rcmd_tdo", o_rspTdo, 0);
      ack();
      chk("rcmd_tap", tapSt, RTI);

      // length above MAX_LEN clamps to 32
      s = nRise;
      issue(2'b00, 6'd40, 32'hFFFF_FFFF, lat);
      chk("clamp_lat", lat, 148);
      chk("clamp_rises", nRise - s, 37);
      chk("clamp_tdo", o_rspTdo, 32'hFFFF_FFFE);
      ack();

      // reset in the middle of a 16-bit DR shift
      i_cmdType = 2'b00; i_cmdLen = 6'd16; i_cmdTdi = 32'h1234; i_cmdValid = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_cmdValid = 1'b0;
      repeat (19) @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      chk("mid_tck", o_tck, 0);
      chk("mid_tms", o_tms, 1);
      chk("mid_rspValid", o_rspValid, 0);
      chk("mid_ready", o_cmdReady, 0);
      chk("mid_rspTdo", o_rspTdo, 0);
      s = nRise;
      i_rst = 1'b0;
      waitReady("reinit_ready");
      chk("reinit_rises", nRise - s, 6);
      chk("reinit_tms", gather(0, s, 6), 64'h1F);
      chk("reinit_tap", tapSt, RTI);
      chk("tck_high_stable", viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end
endmodule
